// File: rtl/sht40_meas_ctrl.sv
// SHT40 measurement sequencer: issues the measure command over a transaction-level
// I2C master, waits out the conversion, reads six bytes and validates both CRC-8 words.
module sht40_meas_ctrl #(
   parameter logic [6:0]  SHT_ADDR  = 7'h44,
   parameter logic [7:0]  MEAS_CMD  = 8'hFD,
   parameter int unsigned WAIT_CYC  = 500000,
   parameter int unsigned MAX_RETRY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic        i2c_req,
   output logic        i2c_rnw,
   output logic [6:0]  i2c_addr,
   output logic [7:0]  i2c_wbyte,
   output logic [2:0]  i2c_nbytes,
   input  logic        i2c_ack,
   input  logic        i2c_rd_valid,
   input  logic [7:0]  i2c_rd_data,
   input  logic        i2c_done,
   input  logic        i2c_nack,
   output logic [15:0] temp_raw,
   output logic [15:0] rh_raw,
   output logic        data_valid,
   output logic        crc_err,
   output logic        nack_err
);

   localparam int TW = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_CYC - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_REQ, S_WR_WAIT, S_MEAS_WAIT, S_RD_REQ, S_RD_DATA, S_CHECK, S_FINISH
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [TW-1:0]   r_timer;
   logic [RW-1:0]   r_retry;
   logic [2:0]      r_byte_cnt;
   logic [7:0]      r_bytes [6];
   logic [15:0]     r_temp;
   logic [15:0]     r_rh;
   logic            r_data_valid;
   logic            r_crc_err;
   logic            r_nack_err;
   logic            w_retry_ok;
   logic            w_read_bad;
   logic            w_crc_ok;

   // CRC-8 (poly 0x31, init 0xFF), one bit per step, MSB first.
   function automatic logic [7:0] crc8(input logic [15:0] data);
      logic [7:0] crc;
      // NOTE: blocking assignments are correct here; this is a pure combinational
      // function evaluated bit by bit, not sequential state.
      crc = 8'hFF;
      for (int i = 15; i >= 0; i--) begin
         if (crc[7] ^ data[i]) crc = (crc << 1) ^ 8'h31;
         else                  crc = crc << 1;
      end
      return crc;
   endfunction

   assign w_retry_ok = (r_retry < RETRY_MAX);
   assign w_read_bad = i2c_nack || (r_byte_cnt != 3'd6);
   assign w_crc_ok   = (crc8({r_bytes[0], r_bytes[1]}) == r_bytes[2]) &&
                       (crc8({r_bytes[3], r_bytes[4]}) == r_bytes[5]);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (start) w_next = S_WR_REQ;
         S_WR_REQ:    if (i2c_ack) w_next = S_WR_WAIT;
         S_WR_WAIT: begin
            if (i2c_done) begin
               if (!i2c_nack)       w_next = S_MEAS_WAIT;
               else if (w_retry_ok) w_next = S_WR_REQ;
               else                 w_next = S_FINISH;
            end
         end
         S_MEAS_WAIT: if (r_timer == TIMER_LAST) w_next = S_RD_REQ;
         S_RD_REQ:    if (i2c_ack) w_next = S_RD_DATA;
         S_RD_DATA:   if (i2c_done) w_next = w_read_bad ? S_FINISH : S_CHECK;
         S_CHECK:     w_next = S_FINISH;
         S_FINISH:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      i2c_req    = 1'b0;
      i2c_rnw    = 1'b0;
      i2c_nbytes = 3'd0;
      case (r_state)
         S_IDLE, S_FINISH: busy = 1'b0;
         S_WR_REQ: begin
            busy       = 1'b1;
            i2c_req    = 1'b1;
            i2c_nbytes = 3'd1;
         end
         S_RD_REQ: begin
            busy       = 1'b1;
            i2c_req    = 1'b1;
            i2c_rnw    = 1'b1;
            i2c_nbytes = 3'd6;
         end
         default: busy = 1'b1;
      endcase
   end

   // Control counters, sticky flags and published results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_timer      <= '0;
         r_retry      <= '0;
         r_byte_cnt   <= '0;
         r_temp       <= '0;
         r_rh         <= '0;
         r_data_valid <= 1'b0;
         r_crc_err    <= 1'b0;
         r_nack_err   <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_crc_err  <= 1'b0;
                  r_nack_err <= 1'b0;
                  r_retry    <= '0;
               end
            end
            S_WR_WAIT: begin
               if (i2c_done) begin
                  if (!i2c_nack)       r_timer    <= '0;
                  else if (w_retry_ok) r_retry    <= r_retry + 1'b1;
                  else                 r_nack_err <= 1'b1;
               end
            end
            S_MEAS_WAIT: r_timer <= r_timer + 1'b1;
            S_RD_REQ:    if (i2c_ack) r_byte_cnt <= '0;
            S_RD_DATA: begin
               // Saturate at 7 so an over-long read still reads as a bad length.
               if (i2c_rd_valid && (r_byte_cnt != 3'd7)) r_byte_cnt <= r_byte_cnt + 1'b1;
               if (i2c_done && w_read_bad) r_nack_err <= 1'b1;
            end
            S_CHECK: begin
               if (w_crc_ok) begin
                  r_temp       <= {r_bytes[0], r_bytes[1]};
                  r_rh         <= {r_bytes[3], r_bytes[4]};
                  r_data_valid <= 1'b1;
               end else begin
                  r_crc_err    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the byte buffer is deliberately not reset; it is always fully
   // rewritten before CHECK reads it, so a reset would only add logic.
   always_ff @(posedge clk) begin
      if ((r_state == S_RD_DATA) && i2c_rd_valid && (r_byte_cnt < 3'd6))
         r_bytes[r_byte_cnt] <= i2c_rd_data;
   end

   assign i2c_addr   = SHT_ADDR;
   assign i2c_wbyte  = MEAS_CMD;
   assign temp_raw   = r_temp;
   assign rh_raw     = r_rh;
   assign data_valid = r_data_valid;
   assign crc_err    = r_crc_err;
   assign nack_err   = r_nack_err;

endmodule
